// File: rtl/cp0_regfile_p_if.sv
// Bus between the pipeline (MEM/WB side) and the CP0 register file:
// mtc0/mfc0 traffic, exception commits, and the forwarded register views.
interface cp0_regfile_p_if #(
   parameter int NUM_HW_INT = 6
);
   logic [4:0]            raddr_i;
   logic [4:0]            waddr_i;
   logic                  we_i;
   logic [31:0]           wdata_i;
   logic [NUM_HW_INT-1:0] int_i;
   logic [31:0]           excepttype_i;
   logic [31:0]           current_inst_addr_i;
   logic                  is_in_delayslot_i;
   logic [31:0]           badvaddr_i;
   logic [31:0]           data_o;
   logic [31:0]           status_o;
   logic [31:0]           cause_o;
   logic [31:0]           epc_o;
   logic                  int_req_o;
   logic                  timer_int_o;
   logic [31:0]           handler_pc_o;

   modport master (
      output raddr_i, waddr_i, we_i, wdata_i, int_i, excepttype_i,
             current_inst_addr_i, is_in_delayslot_i, badvaddr_i,
      input  data_o, status_o, cause_o, epc_o, int_req_o, timer_int_o,
             handler_pc_o
   );

   modport slave (
      input  raddr_i, waddr_i, we_i, wdata_i, int_i, excepttype_i,
             current_inst_addr_i, is_in_delayslot_i, badvaddr_i,
      output data_o, status_o, cause_o, epc_o, int_req_o, timer_int_o,
             handler_pc_o
   );
endinterface

// File: rtl/cp0_regfile_p.sv
// CP0 register file: COUNT with prescaler, COMPARE timer, STATUS/CAUSE/EPC,
// BADVADDR capture on address errors, interrupt request and handler PC.
module cp0_regfile_p #(
   parameter int          NUM_HW_INT = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EXC_BASE   = 32'h0000_0020,
   parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
   parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
   input logic clk,
   input logic rst,
   cp0_regfile_p_if.slave bus
);
   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   localparam logic [4:0] R_BADV = 5'd8,  R_COUNT = 5'd9,  R_COMP   = 5'd11,
                          R_STAT = 5'd12, R_CAUSE = 5'd13, R_EPC    = 5'd14,
                          R_PRID = 5'd15, R_CONF  = 5'd16;

   logic [PW-1:0] presc;
   logic [31:0]   count_q, compare_q, status_q, epc_q, badv_q;
   logic          timer_q, bd_q;
   logic [1:0]    ce_q, sw_q;
   logic [4:0]    exc_q;
   logic [5:0]    ip_q, ip_in;

   logic wr_count, wr_comp, wr_stat, wr_cause, wr_epc, presc_wrap;
   logic exc_hit, exc_upd_epc, exc_adr, eret;
   logic [4:0] exc_code;

   assign wr_count   = bus.we_i && bus.waddr_i == R_COUNT;
   assign wr_comp    = bus.we_i && bus.waddr_i == R_COMP;
   assign wr_stat    = bus.we_i && bus.waddr_i == R_STAT;
   assign wr_cause   = bus.we_i && bus.waddr_i == R_CAUSE;
   assign wr_epc     = bus.we_i && bus.waddr_i == R_EPC;
   assign presc_wrap = presc == PW'(COUNT_DIV - 1);

   always_comb begin
      ip_in = '0;
      for (int k = 0; k < NUM_HW_INT; k++) ip_in[k] = bus.int_i[k];
   end

   always_comb begin
      exc_hit  = 1'b1;
      exc_code = 5'd0;
      case (bus.excepttype_i)
         32'h1:   exc_code = 5'd0;
         32'h4:   exc_code = 5'd4;
         32'h5:   exc_code = 5'd5;
         32'h8:   exc_code = 5'd8;
         32'h9:   exc_code = 5'd9;
         32'ha:   exc_code = 5'd10;
         32'hc:   exc_code = 5'd12;
         32'hd:   exc_code = 5'd13;
         default: exc_hit  = 1'b0;
      endcase
   end

   // A nested exception (EXL already set) keeps the original EPC/BD; interrupts always update.
   assign exc_upd_epc = exc_hit && (bus.excepttype_i == 32'h1 || !status_q[1]);
   assign exc_adr     = bus.excepttype_i == 32'h4 || bus.excepttype_i == 32'h5;
   assign eret        = bus.excepttype_i == 32'he;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc     <= '0;
         count_q   <= '0;
         compare_q <= '0;
         status_q  <= 32'h1000_0000;
         epc_q     <= '0;
         badv_q    <= '0;
         timer_q   <= 1'b0;
         bd_q      <= 1'b0;
         ce_q      <= '0;
         sw_q      <= '0;
         exc_q     <= '0;
         ip_q      <= '0;
      end else begin
         presc <= (wr_count || presc_wrap) ? '0 : presc + PW'(1);
         if (wr_count)        count_q <= bus.wdata_i;
         else if (presc_wrap) count_q <= count_q + 32'd1;
         if (wr_comp) compare_q <= bus.wdata_i;
         timer_q <= wr_comp ? 1'b0
                            : (timer_q | (compare_q != 32'd0 && count_q == compare_q));
         ip_q <= ip_in;
         if (wr_stat) status_q <= bus.wdata_i;
         if (wr_epc)  epc_q    <= bus.wdata_i;
         if (wr_cause) begin
            ce_q <= bus.wdata_i[23:22];
            sw_q <= bus.wdata_i[9:8];
         end
         // Exception fields are assigned after the mtc0 write so they take priority.
         if (exc_hit) begin
            status_q[1] <= 1'b1;
            exc_q       <= exc_code;
            if (exc_upd_epc) begin
               epc_q <= bus.current_inst_addr_i -
                        (bus.is_in_delayslot_i ? 32'd4 : 32'd0);
               bd_q  <= bus.is_in_delayslot_i;
            end
            if (exc_adr) badv_q <= bus.badvaddr_i;
         end
         if (eret) status_q[1] <= 1'b0;
      end
   end

   logic [31:0] status_v, cause_v, epc_v, count_v, compare_v, rd_v;
   logic [1:0]  ce_v, sw_v;
   logic        int_req;

   assign status_v  = wr_stat  ? bus.wdata_i : status_q;
   assign epc_v     = wr_epc   ? bus.wdata_i : epc_q;
   assign count_v   = wr_count ? bus.wdata_i : count_q;
   assign compare_v = wr_comp  ? bus.wdata_i : compare_q;
   assign ce_v      = wr_cause ? bus.wdata_i[23:22] : ce_q;
   assign sw_v      = wr_cause ? bus.wdata_i[9:8]   : sw_q;
   assign cause_v   = {bd_q, 7'd0, ce_v, 6'd0, ip_q[5] | timer_q, ip_q[4:0],
                       sw_v, 1'b0, exc_q, 2'b00};

   always_comb begin
      rd_v = '0;
      case (bus.raddr_i)
         R_BADV:  rd_v = badv_q;
         R_COUNT: rd_v = count_v;
         R_COMP:  rd_v = compare_v;
         R_STAT:  rd_v = status_v;
         R_CAUSE: rd_v = cause_v;
         R_EPC:   rd_v = epc_v;
         R_PRID:  rd_v = PRID_VAL;
         R_CONF:  rd_v = CONFIG_VAL;
         default: rd_v = '0;
      endcase
   end

   assign int_req = status_v[0] & ~status_v[1] & |(cause_v[15:8] & status_v[15:8]);

   assign bus.data_o      = rst ? '0 : rd_v;
   assign bus.status_o    = rst ? '0 : status_v;
   assign bus.cause_o     = rst ? '0 : cause_v;
   assign bus.epc_o       = rst ? '0 : epc_v;
   assign bus.int_req_o   = ~rst & int_req;
   assign bus.timer_int_o = ~rst & timer_q;
   assign bus.handler_pc_o = (rst || bus.excepttype_i == 32'd0) ? '0 :
                             (eret ? epc_v : EXC_BASE);
endmodule

// File: tb/tb_cp0_regfile_p.sv
// Directed test of cp0_regfile_p against a cycle-level behavioural model.
module tb_cp0_regfile_p;
   localparam int          NHW  = 6;
   localparam int          DIV  = 2;
   localparam logic [31:0] BASE = 32'h0000_0020;
   localparam logic [31:0] PRID = 32'h0048_0102;
   localparam logic [31:0] CONF = 32'h0000_8000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cp0_regfile_p_if #(.NUM_HW_INT(NHW)) bus ();
   cp0_regfile_p #(.NUM_HW_INT(NHW), .COUNT_DIV(DIV), .EXC_BASE(BASE),
                   .PRID_VAL(PRID), .CONFIG_VAL(CONF))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h @%0t", nm, act, exp, $time);
      end
   endtask

   // Model: COUNT is the last loaded value plus elapsed clocks / DIV.
   logic [31:0] m_load = 0, m_comp = 0, m_stat = 32'h1000_0000, m_epc = 0, m_badv = 0;
   int unsigned m_cyc  = 0;
   logic        m_timer = 0, m_bd = 0;
   logic [31:0] m_wbits = 0;
   logic [4:0]  m_exc = 0;
   logic [5:0]  m_ip = 0;

   function automatic int exc_of(input logic [31:0] t);
      case (t)
         32'h1: return 0;  32'h4: return 4;  32'h5: return 5;  32'h8: return 8;
         32'h9: return 9;  32'ha: return 10; 32'hc: return 12; 32'hd: return 13;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] m_count();
      return m_load + 32'(m_cyc / DIV);
   endfunction

   function automatic logic wr_to(input int r);
      return bus.we_i && int'(bus.waddr_i) == r;
   endfunction

   function automatic logic [31:0] e_status();
      return wr_to(12) ? bus.wdata_i : m_stat;
   endfunction

   function automatic logic [31:0] e_cause();
      logic [31:0] c;
      c = wr_to(13) ? (bus.wdata_i & 32'h00C0_0300) : m_wbits;
      c[31]    = m_bd;
      c[15:10] = m_ip;
      c[15]    = m_ip[5] | m_timer;
      c[6:2]   = m_exc;
      return c;
   endfunction

   function automatic logic [31:0] e_epc();
      return wr_to(14) ? bus.wdata_i : m_epc;
   endfunction

   function automatic logic [31:0] e_data();
      case (int'(bus.raddr_i))
         8:  return m_badv;
         9:  return wr_to(9) ? bus.wdata_i : m_count();
         11: return wr_to(11) ? bus.wdata_i : m_comp;
         12: return e_status();
         13: return e_cause();
         14: return e_epc();
         15: return PRID;
         16: return CONF;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_load = 0; m_cyc = 0; m_comp = 0; m_stat = 32'h1000_0000; m_epc = 0;
         m_badv = 0; m_timer = 0; m_bd = 0; m_wbits = 0; m_exc = 0; m_ip = 0;
      end else begin
         logic nt, exl;
         int   ec;
         exl = m_stat[1];
         ec  = exc_of(bus.excepttype_i);
         nt  = m_timer || (m_comp != 0 && m_count() == m_comp);
         if (wr_to(11)) begin nt = 1'b0; m_comp = bus.wdata_i; end
         if (wr_to(9)) begin m_load = bus.wdata_i; m_cyc = 0; end
         else m_cyc++;
         if (wr_to(12)) m_stat  = bus.wdata_i;
         if (wr_to(14)) m_epc   = bus.wdata_i;
         if (wr_to(13)) m_wbits = bus.wdata_i & 32'h00C0_0300;
         m_ip = 6'(bus.int_i);
         if (ec >= 0) begin
            if (ec == 0 || !exl) begin
               m_epc = bus.is_in_delayslot_i ? bus.current_inst_addr_i - 4
                                             : bus.current_inst_addr_i;
               m_bd  = bus.is_in_delayslot_i;
            end
            m_stat[1] = 1'b1;
            m_exc     = 5'(ec);
            if (ec == 4 || ec == 5) m_badv = bus.badvaddr_i;
         end
         if (bus.excepttype_i == 32'he) m_stat[1] = 1'b0;
         m_timer = nt;
      end
   end

   always @(negedge clk) begin
      logic [31:0] st, ca, hp;
      logic        ir;
      st = rst ? 32'd0 : e_status();
      ca = rst ? 32'd0 : e_cause();
      ir = !rst && st[0] && !st[1] && |(ca[15:8] & st[15:8]);
      hp = (rst || bus.excepttype_i == 0) ? 32'd0 :
           (bus.excepttype_i == 32'he ? e_epc() : BASE);
      chk("m_data",   bus.data_o,   rst ? 32'd0 : e_data());
      chk("m_status", bus.status_o, st);
      chk("m_cause",  bus.cause_o,  ca);
      chk("m_epc",    bus.epc_o,    rst ? 32'd0 : e_epc());
      chk("m_intreq", 32'(bus.int_req_o),   32'(ir));
      chk("m_timer",  32'(bus.timer_int_o), 32'(!rst && m_timer));
      chk("m_hpc",    bus.handler_pc_o, hp);
   end

   task automatic tick; @(posedge clk); #1; endtask
   task automatic settle; #2; endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
      tick;
      bus.we_i = 1'b0;
   endtask

   initial begin
      bus.raddr_i = 5'd12; bus.waddr_i = 0; bus.we_i = 0; bus.wdata_i = 0;
      bus.int_i = 0; bus.excepttype_i = 0; bus.current_inst_addr_i = 0;
      bus.is_in_delayslot_i = 0; bus.badvaddr_i = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_status", bus.status_o, 32'd0);
      chk("rst_data",   bus.data_o,   32'd0);
      rst = 1'b0;
      settle;
      chk("status_init", bus.status_o, 32'h1000_0000);

      // 1: prescaled COUNT and wrap
      bus.raddr_i = 5'd9;
      repeat (10) tick;
      settle; chk("count_10clk", bus.data_o, 32'd5);
      bus.we_i = 1'b1; bus.waddr_i = 5'd9; bus.wdata_i = 32'hFFFF_FFFF;
      settle; chk("count_fwd", bus.data_o, 32'hFFFF_FFFF);
      tick; bus.we_i = 1'b0;
      repeat (2) tick;
      settle; chk("count_wrap", bus.data_o, 32'd0);

      // 2: timer match, then COMPARE write colliding with a match
      wr(5'd11, 32'd20);
      wr(5'd9, 32'd18);
      repeat (4) tick;
      settle; chk("timer_pre", 32'(bus.timer_int_o), 32'd0);
      tick;
      settle; chk("timer_set", 32'(bus.timer_int_o), 32'd1);
      chk("cause15_timer", 32'(bus.cause_o[15]), 32'd1);
      wr(5'd11, 32'd50);
      wr(5'd9, 32'd49);
      repeat (2) tick;
      settle; chk("count_50", bus.data_o, 32'd50);
      wr(5'd11, 32'd0);
      settle; chk("timer_clr_wins", 32'(bus.timer_int_o), 32'd0);

      // 3: hardware interrupt request, then Int exception
      wr(5'd12, 32'h0000_0401);
      bus.int_i = 6'b000001;
      tick;
      settle; chk("int_req_on", 32'(bus.int_req_o), 32'd1);
      bus.excepttype_i = 32'h1; bus.current_inst_addr_i = 32'h100;
      settle; chk("hpc_int", bus.handler_pc_o, 32'h20);
      tick; bus.excepttype_i = 0;
      settle;
      chk("epc_int", bus.epc_o, 32'h100);
      chk("status_exl", bus.status_o, 32'h0000_0403);
      chk("int_req_off", 32'(bus.int_req_o), 32'd0);
      bus.int_i = 0;

      // 4: AdEL in a delay slot
      wr(5'd12, 32'd0);
      bus.excepttype_i = 32'h4; bus.badvaddr_i = 32'hBFC0_0003;
      bus.is_in_delayslot_i = 1'b1; bus.current_inst_addr_i = 32'h208;
      settle; chk("hpc_adel", bus.handler_pc_o, 32'h20);
      tick; bus.excepttype_i = 0; bus.is_in_delayslot_i = 0;
      bus.raddr_i = 5'd8;
      settle;
      chk("epc_ds", bus.epc_o, 32'h204);
      chk("cause_adel", bus.cause_o, 32'h8000_0010);
      chk("badvaddr", bus.data_o, 32'hBFC0_0003);

      // 5: nested Sys keeps EPC, then ERET
      bus.excepttype_i = 32'h8; bus.current_inst_addr_i = 32'h300;
      tick; bus.excepttype_i = 0;
      settle;
      chk("epc_nested", bus.epc_o, 32'h204);
      chk("cause_sys", bus.cause_o, 32'h8000_0020);
      bus.excepttype_i = 32'he;
      settle; chk("hpc_eret", bus.handler_pc_o, 32'h204);
      tick; bus.excepttype_i = 0;
      settle; chk("status_eret", bus.status_o, 32'd0);

      // 6: mtc0 CAUSE racing an Ov exception
      bus.we_i = 1'b1; bus.waddr_i = 5'd13; bus.wdata_i = 32'hFFFF_FFFF;
      bus.excepttype_i = 32'hc; bus.current_inst_addr_i = 32'h400;
      settle; chk("cause_fwd", bus.cause_o, 32'h80C0_0320);
      tick; bus.we_i = 1'b0; bus.excepttype_i = 0;
      settle;
      chk("cause_ov", bus.cause_o, 32'h00C0_0330);
      chk("epc_ov", bus.epc_o, 32'h400);

      // read-only and unmapped registers
      wr(5'd15, 32'h1234_5678);
      bus.raddr_i = 5'd15; settle; chk("prid", bus.data_o, PRID);
      bus.raddr_i = 5'd16; #1;     chk("config", bus.data_o, CONF);
      bus.raddr_i = 5'd5;  #1;     chk("unmapped", bus.data_o, 32'd0);

      // async reset mid-count, checked before any further clock edge
      bus.raddr_i = 5'd9;
      repeat (3) tick;
      rst = 1'b1; #1;
      chk("rst_mid_data", bus.data_o, 32'd0);
      rst = 1'b0; #1;
      chk("rst_mid_count", bus.data_o, 32'd0);
      chk("rst_mid_status", bus.status_o, 32'h1000_0000);
      repeat (3) tick;
      settle; chk("count_after_rst", bus.data_o, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
